// File: rtl/instr_buffer_pkg.sv
// Front-end shared types: the fetch/decode packet and the default buffer depth.
package instr_buffer_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_packet_t;

    localparam int IBUF_DEPTH = 4;

endpackage : instr_buffer_pkg

// File: rtl/instr_buffer.sv
// Circular FIFO of {pc, instr} pairs between fetch and decode, first-word-fall-through,
// emptied by a branch-redirect flush.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter type T     = word_t,
    parameter int  DEPTH = IBUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         valid_in,
    input  T                             pc_in,
    input  T                             instr_in,
    output logic                         ready_to_fetch,
    output logic                         valid_out,
    output T                             pc_out,
    output T                             instr_out,
    input  logic                         ready_in,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    fetch_packet_t   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    fetch_packet_t   wr_pkt_s;
    fetch_packet_t   head_s;

    // Status flags and handshakes derived from the pointer pair only
    always_comb begin
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        push_s    = valid_in && !full_s && !flush;
        pop_s     = !empty_s && ready_in && !flush;
        wr_pkt_s  = '{pc: pc_in, instr: instr_in};
        head_s    = mem_q[rd_ptr_q[AW-1:0]];
    end

    assign ready_to_fetch = !full_s;
    assign valid_out      = !empty_s;
    assign pc_out         = head_s.pc;
    assign instr_out      = head_s.instr;
    assign occupancy      = OW'(wr_ptr_q - rd_ptr_q);

    // Pointer next-state; a flush rewinds both pointers and swallows that cycle's push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer and storage registers; reset also clears storage so the head reads as zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_pkt_s;
            end
        end
    end

endmodule : instr_buffer

// File: doc/instr_buffer.md
# instr_buffer

Instruction buffer between `fetch` and decode. It accepts `{pc, instr}` pairs from `fetch` under a valid/ready handshake and stores them in a small circular FIFO. It presents them in order to decode under a second valid/ready handshake. This decouples decode stalls from the fetch PC register, and all buffered instructions are discarded when a branch redirect flushes the front end.

## Interface
Parameters:
- `T`, `logic [31:0]`: instruction/PC word type, same as `fetch`.
- `DEPTH`, `4`: entry count; a power of two, at least 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low (asserted when 0).
- `flush` input 1: branch redirect; driven by the same signal as `fetch.take_branch`.
- `valid_in` input 1: `fetch.valid`; a pair is offered.
- `pc_in` input `T`: `fetch.pc_to_decode`.
- `instr_in` input `T`: `fetch.instr_to_decode`.
- `ready_to_fetch` output 1: drives `fetch.ready`; buffer can accept.
- `valid_out` output 1: head entry is valid.
- `pc_out` output `T`: PC of head entry.
- `instr_out` output `T`: instruction of head entry.
- `ready_in` input 1: decode consumes the head this cycle.
- `occupancy` output `$clog2(DEPTH+1)`: current entry count.

## Operation
- Storage: `DEPTH` entries of `{pc, instr}`.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(DEPTH)+1` bits; the MSB is a wrap bit.
  - `empty` = pointers equal.
  - `full` = index bits equal and wrap bits differ.
  - `occupancy` = `wr_ptr - rd_ptr`, taken modulo the pointer width.
- Push = `valid_in && ready_to_fetch`. Writes the entry at `wr_ptr` and increments `wr_ptr`.
- Pop = `valid_out && ready_in`. Increments `rd_ptr`.
- `ready_to_fetch` = `!full`. Purely from state; there is no combinational path from `ready_in`.
- `valid_out` = `!empty`. `pc_out`/`instr_out` are read combinationally from `rd_ptr` (first-word-fall-through).
- Push and pop in the same cycle: both take effect and occupancy is unchanged.
  - When full, push is blocked, so a pop while full does not admit a same-cycle write.
  - When empty, pop is impossible. An entry pushed into an empty buffer is not forwarded in the same cycle.
- Flush (`flush=1` on an edge):
  - Both pointers go to 0.
  - Any same-cycle push is dropped and any same-cycle pop has no effect.
  - Storage contents are not cleared.
- Reset takes priority over flush. Reset mid-operation discards all entries, exactly like flush, and also zeroes storage.
- No state machine beyond the pointer pair. Pointer arithmetic wraps naturally at `2*DEPTH`.

## Timing
Values one edge after reset is sampled low:
- `valid_out`=0
- `ready_to_fetch`=1
- `occupancy`=0
- `pc_out`=0
- `instr_out`=0

Latency and cycle-level behaviour:
- Latency: a pair accepted at edge N is visible on `valid_out`/`pc_out`/`instr_out` after edge N (before edge N+1), when the buffer was empty. Fall-through latency is one cycle.
- Throughput: one push and one pop per cycle sustained.
- `ready_to_fetch` falls in the cycle after the push that fills the buffer. It rises in the cycle after the first pop from full.
- Flush: after the flush edge, `valid_out`=0 and `ready_to_fetch`=1. `fetch` drops its own valid on the same edge, so the first post-branch pair arrives after that, with the same one-cycle bubble `fetch` already has.
- Handshake rules:
  - `pc_out`/`instr_out` remain stable while `valid_out && !ready_in`.
  - The upstream contract requires `fetch` to hold `pc_in`/`instr_in` stable while `valid_in && !ready_to_fetch`.

## Structure
- Shared front-end package holds:
  - `typedef struct packed { T pc; T instr; } fetch_packet_t`
  - `IBUF_DEPTH = 4`
- Storage is an array of `fetch_packet_t`.
- Flat single module; no sub-module is warranted. Pointer/full/empty logic is under 30 lines and is not reused elsewhere.
- Top-level instantiation: `fetch -> instr_buffer -> decode`. `flush` is tied to the branch-redirect signal that drives `fetch.take_branch`.

## Test plan
- **Reset:** hold `reset=0` for 2 edges with `valid_in=1`.
  - During reset: `valid_out`=0, `occupancy`=0.
  - After reset edge: `ready_to_fetch`=1.
- **Streaming:** push PCs 0x0, 0x4, 0x8 with data `0xAA000000|pc`, `ready_in=1`.
  - `pc_out` follows one cycle behind, in order.
  - `occupancy` stays 1.
- **Fill/backpressure:** `ready_in=0`, push 5 pairs (PC 0x10–0x20), DEPTH=4.
  - After 4 pushes: `ready_to_fetch`=0 and `occupancy`=4.
  - The fifth pair is held, not written.
  - Raising `ready_in` drains 0x10, 0x14, 0x18, 0x1C, then 0x20 is accepted.
- **Wrap-around:** 10 pushes with pops interleaved so occupancy alternates between 2 and 3.
  - Output sequence exactly equals input sequence across two pointer wraps.
- **Flush with simultaneous push/pop:** occupancy 3, `flush=1`, `valid_in=1` (PC 0x40), `ready_in=1` on one edge.
  - Next cycle: `occupancy`=0, `valid_out`=0.
  - The next push of PC 0x40 appears at `pc_out` one cycle later.
- **Reset mid-operation:** occupancy 2 and `flush=1`, assert `reset=0` for one edge.
  - All outputs are at reset values, including `pc_out`=0.
  - Normal operation resumes on release.
